// File: rtl/vecmac_accum.sv
// Result-side accumulator for the int8 vector MAC: sums cfg_len+1 tree beats per vector and queues results in a FIFO.
// Optional: define VECMAC_ACCUM_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module vecmac_accum #(
  parameter int SUMW       = 19,
  parameter int ACCW       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [7:0]      cfg_len,
  input  logic            in_valid,
  input  logic [SUMW-1:0] in_sum,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [ACCW-1:0] res_data,
  output logic            res_ovf,
  output logic            busy,
  output logic            drop_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, ACC} state_t;

  state_t          r_state;
  logic [7:0]      r_count;
  logic [7:0]      r_len;
  logic [ACCW-1:0] r_acc;
  logic            r_ovf;
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic            r_drop_err;
  logic [ACCW:0]   r_mem [FIFO_DEPTH];

  logic [ACCW-1:0] w_sum_ext;
  logic [ACCW:0]   w_add;
  logic            w_beat;
  logic            w_last;
  logic [ACCW-1:0] w_final;
  logic            w_final_ovf;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;

  // Bit ACCW of the return value is the carry-out; the low bits are the new accumulator.
  function automatic logic [ACCW:0] add_acc(input logic [ACCW-1:0] a, input logic [ACCW-1:0] b);
    logic [ACCW:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef VECMAC_ACCUM_SAT_EN
    if (s[ACCW]) s[ACCW-1:0] = '1;
`endif
    return s;
  endfunction

  always_comb begin
    w_sum_ext   = ACCW'(in_sum);
    w_add       = add_acc(r_acc, w_sum_ext);
    w_beat      = in_valid && !clear;
    w_last      = w_beat && (((r_state == IDLE) && (cfg_len == 8'd0)) ||
                             ((r_state == ACC) && (r_count == r_len)));
    w_final     = (r_state == IDLE) ? w_sum_ext : w_add[ACCW-1:0];
    w_final_ovf = (r_state == IDLE) ? 1'b0 : (r_ovf | w_add[ACCW]);
    w_empty     = (r_wr_ptr == r_rd_ptr);
    w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop       = !w_empty && res_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    w_push      = w_last && (!w_full || w_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= 8'd0;
      r_len      <= 8'd0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drop_err <= 1'b0;
    end else if (clear) begin
      r_state    <= IDLE;
      r_count    <= 8'd0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drop_err <= 1'b0;
    end else begin
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_last && !w_push) r_drop_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_len <= cfg_len;
            if (cfg_len != 8'd0) begin
              r_state <= ACC;
              r_count <= 8'd1;
              r_acc   <= w_sum_ext;
              r_ovf   <= 1'b0;
            end
          end
        end
        ACC: begin
          if (in_valid) begin
            if (r_count == r_len) begin
              r_state <= IDLE;
              r_count <= 8'd0;
              r_ovf   <= 1'b0;
            end else begin
              r_acc   <= w_add[ACCW-1:0];
              r_count <= r_count + 8'd1;
              r_ovf   <= w_final_ovf;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_final_ovf, w_final};
  end

  // Storage is never reset, so the head is masked to zero whenever the FIFO is empty.
  always_comb begin
    res_valid           = !w_empty;
    {res_ovf, res_data} = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    busy                = (r_state == ACC);
    drop_err            = r_drop_err;
  end

endmodule
